// File: rtl/sap_controller_sequencer_if.sv
// SAP-1 controller bundle: run/opcode in, T-state and control word out.
// master = sequencer, slave = datapath side.
interface sap_controller_sequencer_if #(
  parameter int OpcodeWidth = 4
);
  logic                   run;
  logic [OpcodeWidth-1:0] opcode;
  logic [5:0]             tstate;
  logic                   halted;
  logic                   pc_inc;
  logic                   pc_en;
  logic                   mar_ld;
  logic                   rom_ce_bar;
  logic                   ir_ld;
  logic                   ir_en;
  logic                   a_ld;
  logic                   a_en;
  logic                   alu_sub;
  logic                   alu_en;
  logic                   b_ld;
  logic                   out_ld;

  modport master (
    input  run, opcode,
    output tstate, halted,
    output pc_inc, pc_en, mar_ld, rom_ce_bar,
    output ir_ld, ir_en, a_ld, a_en,
    output alu_sub, alu_en, b_ld, out_ld
  );

  modport slave (
    output run, opcode,
    input  tstate, halted,
    input  pc_inc, pc_en, mar_ld, rom_ce_bar,
    input  ir_ld, ir_en, a_ld, a_en,
    input  alu_sub, alu_en, b_ld, out_ld
  );
endinterface

// File: rtl/sap_controller_sequencer.sv
// SAP-1 controller-sequencer: one-hot T1..T6 ring counter
// decoding the IR opcode into the per-cycle control word.
module sap_controller_sequencer #(
  parameter int                   OpcodeWidth = 4,
  parameter logic                 RomCeLevel  = 1'b1,
  parameter logic [OpcodeWidth-1:0] OpLDA     = 'h0,
  parameter logic [OpcodeWidth-1:0] OpADD     = 'h1,
  parameter logic [OpcodeWidth-1:0] OpSUB     = 'h2,
  parameter logic [OpcodeWidth-1:0] OpOUT     = 'hE,
  parameter logic [OpcodeWidth-1:0] OpHLT     = 'hF
) (
  input logic clk,
  input logic rst,
  sap_controller_sequencer_if.master bus
);

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T4 = 6'b001000;

  logic [5:0] tstate;
  logic       halted;
  logic       go;

  logic is_lda, is_add, is_sub, is_out, is_hlt;
  logic is_mem;

  logic pc_inc, pc_en, mar_ld, rom_oe;
  logic ir_ld, ir_en, a_ld, a_en;
  logic alu_sub, alu_en, b_ld, out_ld;

  assign go     = bus.run && !halted;
  assign is_lda = bus.opcode == OpLDA;
  assign is_add = bus.opcode == OpADD;
  assign is_sub = bus.opcode == OpSUB;
  assign is_out = bus.opcode == OpOUT;
  assign is_hlt = bus.opcode == OpHLT;
  assign is_mem = is_lda || is_add || is_sub;

  always_ff @(posedge clk) begin
    if (rst) begin
      tstate <= T1;
      halted <= 1'b0;
    end else if (go) begin
      if (tstate == T4 && is_hlt) begin
        halted <= 1'b1;
      end else begin
        tstate <= {tstate[4:0], tstate[5]};
      end
    end
  end

  always_comb begin
    pc_inc  = 1'b0;
    pc_en   = 1'b0;
    mar_ld  = 1'b0;
    rom_oe  = 1'b0;
    ir_ld   = 1'b0;
    ir_en   = 1'b0;
    a_ld    = 1'b0;
    a_en    = 1'b0;
    alu_sub = 1'b0;
    alu_en  = 1'b0;
    b_ld    = 1'b0;
    out_ld  = 1'b0;
    if (!rst && go) begin
      unique case (1'b1)
        tstate[0]: begin
          pc_en  = 1'b1;
          mar_ld = 1'b1;
        end
        tstate[1]: pc_inc = 1'b1;
        tstate[2]: begin
          rom_oe = 1'b1;
          ir_ld  = 1'b1;
        end
        tstate[3]: begin
          ir_en  = is_mem;
          mar_ld = is_mem;
          a_en   = is_out;
          out_ld = is_out;
        end
        tstate[4]: begin
          rom_oe = is_mem;
          a_ld   = is_lda;
          b_ld   = is_add || is_sub;
        end
        tstate[5]: begin
          alu_en  = is_add || is_sub;
          alu_sub = is_sub;
          a_ld    = is_add || is_sub;
        end
        default: ;
      endcase
    end
  end

  assign bus.tstate     = tstate;
  assign bus.halted     = halted;
  assign bus.pc_inc     = pc_inc;
  assign bus.pc_en      = pc_en;
  assign bus.mar_ld     = mar_ld;
  assign bus.rom_ce_bar = rom_oe ? RomCeLevel : ~RomCeLevel;
  assign bus.ir_ld      = ir_ld;
  assign bus.ir_en      = ir_en;
  assign bus.a_ld       = a_ld;
  assign bus.a_en       = a_en;
  assign bus.alu_sub    = alu_sub;
  assign bus.alu_en     = alu_en;
  assign bus.b_ld       = b_ld;
  assign bus.out_ld     = out_ld;

  one_bus_driver: assert property (@(posedge clk)
    $onehot0({pc_en, rom_oe, ir_en, a_en, alu_en}));

  sub_needs_alu: assert property (@(posedge clk)
    alu_sub |-> alu_en);

endmodule

// File: doc/sap_controller_sequencer.md
Name: sap_controller_sequencer

Overview:
Controller-sequencer for the SAP-1 datapath. A six-state one-hot ring counter (T1..T6) decodes the 4-bit instruction opcode into the per-cycle control word. This control word drives the program counter, MAR, program ROM chip enable, IR, accumulator, ALU, B register and output register. The block sits between the IR opcode field and every datapath load/enable pin, and owns the run/halt state of the machine.

Parameters:
OpcodeWidth, 4, width of opcode input.
RomCeLevel, 1'b1, level driven on rom_ce_bar when the ROM must drive the bus; the inactive level is its complement.
OpLDA, 4'h0, LDA opcode.
OpADD, 4'h1, ADD opcode.
OpSUB, 4'h2, SUB opcode.
OpOUT, 4'hE, OUT opcode.
OpHLT, 4'hF, HLT opcode.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-high.
run  in  1  1 = sequencer advances; 0 = freeze (single-step/pause).
opcode  in  OpcodeWidth  IR upper nibble; sampled combinationally in T4..T6 only.
tstate  out  6  one-hot T-state, bit0 = T1.
halted  out  1  high once HLT is executed.
pc_inc  out  1  program counter increment (Cp).
pc_en  out  1  PC drives bus (Ep).
mar_ld  out  1  MAR load (Lm).
rom_ce_bar  out  1  ROM output enable, at RomCeLevel when active.
ir_ld  out  1  IR load (Li).
ir_en  out  1  IR operand nibble drives bus (Ei).
a_ld  out  1  accumulator load (La).
a_en  out  1  accumulator drives bus (Ea).
alu_sub  out  1  ALU subtract select (Su).
alu_en  out  1  ALU drives bus (Eu).
b_ld  out  1  B register load (Lb).
out_ld  out  1  output register load (Lo).

Behaviour:
- Synchronous, active-high reset on rising clk, overriding all other inputs.
  - Reset values: tstate = 6'b000001 (T1), halted = 0.
- Control outputs are a combinational decode of registered tstate, halted, run and opcode. Except for rom_ce_bar, all are active-high with an inactive value of 0.
- While rst = 1, all control outputs are inactive and rom_ce_bar = ~RomCeLevel.
- Advance rule: when run = 1 and halted = 0, tstate rotates T1->T2->...->T6->T1 each clock.
  - Every instruction takes exactly 6 cycles, NOPs included.
- When run = 0, tstate and halted hold. All control outputs are forced inactive, so there are no repeated PC increments and no bus contention.
- Decode when run = 1 and halted = 0:
  - T1: pc_en, mar_ld.
  - T2: pc_inc.
  - T3: rom_ce_bar active, ir_ld.
  - T4 by opcode:
    - LDA/ADD/SUB: ir_en, mar_ld.
    - OUT: a_en, out_ld.
    - HLT: none.
    - Other opcodes: none.
  - T5 by opcode:
    - LDA: rom_ce_bar active, a_ld.
    - ADD/SUB: rom_ce_bar active, b_ld.
    - Others: none.
  - T6 by opcode:
    - ADD: alu_en, a_ld.
    - SUB: alu_en, alu_sub, a_ld.
    - Others: none.
- HLT: in T4 with opcode == OpHLT and run = 1, the next edge sets halted = 1 and tstate stays T4.
  - While halted, all control outputs are inactive.
  - Only rst clears halted. run is ignored while halted.
- At most one bus driver (pc_en, rom_ce_bar active, ir_en, a_en, alu_en) is active in any cycle. This invariant is asserted in simulation.
- alu_sub is asserted only together with alu_en.
- Reset mid-instruction: the next cycle is T1, with no partial strobes beyond the reset cycle.
- Unknown opcodes behave as 6-cycle NOPs after the fetch cycles T1..T3.

Test Plan:
- Reset then run = 1, opcode = 4'h0 (LDA) -> tstate sequence 01,02,04,08,10,20,01 (hex).
  - pc_en+mar_ld at T1, pc_inc at T2, rom_ce_bar = 1 + ir_ld at T3, ir_en+mar_ld at T4, rom_ce_bar = 1 + a_ld at T5, nothing at T6.
- opcode = 4'h2 (SUB) -> T5: rom_ce_bar = 1 + b_ld; T6: alu_en = alu_sub = a_ld = 1. With opcode = 4'h1 (ADD), T6 has alu_sub = 0.
- opcode = 4'hE (OUT) -> T4: a_en = out_ld = 1. T5 and T6 all outputs inactive. The one-bus-driver assertion never fires across 100 random opcodes.
- opcode = 4'hF at T4 -> halted = 1 on the next edge and tstate holds 6'h08 for 20 cycles with all outputs 0. Then rst = 1 for 1 cycle -> tstate = 01, halted = 0.
- run dropped to 0 during T2 for 5 cycles -> tstate holds 02, pc_inc = 0 throughout. After run returns to 1, pc_inc = 1 for exactly one cycle, then tstate = 04.
- rst asserted at T5 of ADD -> next cycle tstate = 01, b_ld is not asserted after the reset edge, and rom_ce_bar = ~RomCeLevel during reset.
